rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ writeback requesters, e.g. ALU writeback, load return and multiply/divide unit.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin. The winner is captured into one registered output stage that drives the register-file write port one cycle later.
- Sits between the writeback sources and the register file in the multi-source datapath.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination registers; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- wr_hold  in  1  freeze: write port must not fire; output stage holds.
- we3  out  1  register-file write enable.
- wa3  out  AW  register-file write address.
- wd3  out  DW  register-file write data.
- busy  out  1  output stage holds a pending write.

Behaviour:
- State:
  - Output stage: valid_q, wa_q, wd_q.
  - Round-robin pointer ptr, log2(NREQ) bits, holding the index of the last winner.
- Reset (synchronous):
  - valid_q=0, wa_q=0, wd_q=0, ptr=NREQ-1, so requester 0 has top priority first.
  - While reset is high: req_ready=0, we3=0.
- Outputs:
  - we3 = valid_q && !wr_hold && (wa_q != 0).
  - wa3 = wa_q; wd3 = wd_q; busy = valid_q.
- Stage accept: can_accept = !valid_q || !wr_hold. The stage drains whenever it is not held, because the register file always accepts a write.
- Grant:
  - When can_accept is high, search req_valid starting at index (ptr+1) mod NREQ, wrapping.
  - The first set bit wins and req_ready gets exactly that bit.
  - req_ready is combinational from req_valid and may depend on it. Requesters must not make valid depend on ready.
  - If no requester is valid or can_accept is low, req_ready=0.
- On a granted transfer:
  - valid_q<=1, wa_q<=winner addr, wd_q<=winner data, ptr<=winner index.
- With no transfer: valid_q<=0 if the stage drained (valid_q && !wr_hold); otherwise hold.
- Latency: a write accepted in cycle N appears on we3 in cycle N+1, unless held.
- Throughput: one write per cycle.
- Register 0:
  - Writes to r0 are accepted and consume a slot; we3 stays low for them.
  - They still update ptr.
- Simultaneous requests to the same register:
  - Serialized in grant order.
  - The later-granted value lands last and wins in the register file.
- Holding: a requester that is valid but not granted must hold its addr/data stable. The arbiter samples data only on the grant cycle.
- wr_hold asserted while valid_q=1: the stage keeps its contents, no grants, we3=0. Release resumes at the next edge.
- wr_hold with valid_q=0: the stage can still accept one write, which is then held.
- Reset mid-operation: a pending output-stage write is discarded, not written, and ptr returns to NREQ-1.
- Fairness: any continuously valid requester is granted within NREQ accepting cycles.

Optional Feature:
- RF_WR_BYPASS_EN
  - Defined: adds inputs byp_ra1 and byp_ra2 (AW each) and outputs byp_hit1, byp_hit2 (1 each) and byp_rd1, byp_rd2 (DW each).
  - byp_hitk = valid_q && (wa_q != 0) && (wa_q == byp_rak); byp_rdk = wd_q when hit, else 0.
  - Purely combinational from the output stage, so readers see a pending write before it reaches the register file.
- Undefined: these ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package rf_pkg: REG_AW=5, REG_DW=32, REG_ZERO=5'd0, and a typedef rf_wr_t struct {valid, addr, data} for the output stage.
- One sub-module: rr_arbiter.
  - Parameterized NREQ.
  - Inputs: req, ptr, enable.
  - Output: one-hot grant plus encoded winner index.
  - Purely combinational.
- Pointer and output stage live in rf_write_arbiter.

Test Plan:
- Reset, then req_valid=001, addr=3, data=0xDEADBEEF → req_ready=001 that cycle; next cycle we3=1, wa3=3, wd3=0xDEADBEEF; following cycle we3=0, busy=0.
- All three valid continuously with distinct addrs 1/2/3 → grants cycle 0,1,2,0,1,2; we3 fires every cycle from the second cycle.
- Req0 writes r0 with data 0x1234 → req_ready[0]=1; next cycle busy=1, we3=0.
- Accept write addr=5 data=0xA5 → next cycle assert wr_hold for 3 cycles with req1 valid. Required: we3=0, req_ready=0, wa3=5 held. Release → we3=1 with wd3=0xA5; req1 granted in the release cycle.
- Req0 and req2 both write r7 (0x11, 0x22) from reset → req0 first, then req2; register 7 ends at 0x22.
- Accept write then assert reset before drain → we3 never fires; after reset req_valid=110 grants req1 first.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: default widths,
// the hard-wired zero register index and the output-stage record type.
package rf_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // One pending register-file write as held in the arbiter's output stage.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past the last
// winner (ptr_i) and wraps, so the last winner has the lowest priority.
// Produces a one-hot grant and the encoded index of the winner.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   input  logic            enable_i,
   output logic [NREQ-1:0] grant_o,
   output logic [PW-1:0]   idx_o
);

   int   k;
   logic found;

   // Rotating priority search: first requester after ptr_i wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      k       = 0;
      for (int i = 1; i <= NREQ; i++) begin
         k = (int'(ptr_i) + i) % NREQ;
         if (enable_i && !found && req_i[k]) begin
            found      = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = PW'(k);
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: NREQ writeback sources compete for the
// single we3/wa3/wd3 port through a round-robin grant and one registered
// output stage. Writes to r0 occupy a slot but never raise we3.
// Optional feature macro: RF_WR_BYPASS_EN adds two read-bypass lookups into
// the pending output-stage write.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic             wr_hold,
   output logic             we3,
   output logic [AW-1:0]    wa3,
   output logic [DW-1:0]    wd3,
`ifdef RF_WR_BYPASS_EN
   input  logic [AW-1:0]    byp_ra1,
   input  logic [AW-1:0]    byp_ra2,
   output logic             byp_hit1,
   output logic             byp_hit2,
   output logic [DW-1:0]    byp_rd1,
   output logic [DW-1:0]    byp_rd2,
`endif
   output logic             busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic            valid_q, valid_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic [PW-1:0]   ptr_q, ptr_d;

   logic            can_accept;
   logic            arb_en;
   logic            xfer;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   win_idx;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;

   // The register file always takes a write, so the stage frees up unless held.
   assign can_accept = !valid_q || !wr_hold;
   assign arb_en     = can_accept && !reset;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_arbiter (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .enable_i (arb_en),
      .grant_o  (grant),
      .idx_o    (win_idx)
   );

   assign req_ready = grant;
   assign xfer      = |(req_valid & grant);

   // Select the winner's address and data with a one-hot AND-OR mux.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_addr = win_addr | req_addr[i*AW +: AW];
            win_data = win_data | req_data[i*DW +: DW];
         end
      end
   end

   // Next state of the output stage and the round-robin pointer.
   always_comb begin
      valid_d = valid_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         valid_d = 1'b1;
         wa_d    = win_addr;
         wd_d    = win_data;
         ptr_d   = win_idx;
      end else if (valid_q && !wr_hold) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset drops any pending write and gives requester 0 priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         ptr_q   <= PW'(NREQ - 1);
      end else begin
         valid_q <= valid_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         ptr_q   <= ptr_d;
      end
   end

   assign we3  = valid_q && !wr_hold && (wa_q != ZERO_ADDR) && !reset;
   assign wa3  = wa_q;
   assign wd3  = wd_q;
   assign busy = valid_q;

`ifdef RF_WR_BYPASS_EN
   // Readers see the pending write one cycle before it lands in the file.
   assign byp_hit1 = valid_q && (wa_q != ZERO_ADDR) && (wa_q == byp_ra1);
   assign byp_hit2 = valid_q && (wa_q != ZERO_ADDR) && (wa_q == byp_ra2);
   assign byp_rd1  = byp_hit1 ? wd_q : '0;
   assign byp_rd2  = byp_hit2 ? wd_q : '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (default build, bypass absent).
// Directed scenarios followed by constrained-random traffic, all checked
// against a behavioural model of the write port and register file.
module tb_rf_write_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]    rv;
   logic [NREQ*AW-1:0] ra;
   logic [NREQ*DW-1:0] rd;
   logic [NREQ-1:0]    ready;
   logic              hold;
   logic              we3;
   logic [AW-1:0]     wa3;
   logic [DW-1:0]     wd3;
   logic              busy;

   always #5 clk = ~clk;

   rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (rv),
      .req_addr  (ra),
      .req_data  (rd),
      .req_ready (ready),
      .wr_hold   (hold),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .busy      (busy)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: one pending slot, last winner, register file contents.
   bit              m_valid;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_data;
   int              m_last;
   logic [NREQ-1:0] m_grant;
   logic [DW-1:0]   m_rf [32];
   logic [DW-1:0]   d_rf [32];
   int              waitc [NREQ];

   logic [NREQ-1:0] o_ready;
   logic            o_we;
   logic [AW-1:0]   o_wa;
   logic [DW-1:0]   o_wd;
   logic            o_busy;

   task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rv[i]            = v;
      ra[i*AW +: AW]   = a;
      rd[i*DW +: DW]   = d;
   endtask

   // One clock: check outputs at the falling edge, advance the model, return after the rising edge.
   task automatic cyc();
      logic [NREQ-1:0] er;
      bit              can;
      bit              ewe;
      int              win;
      @(negedge clk);
      o_ready = ready;
      o_we    = we3;
      o_wa    = wa3;
      o_wd    = wd3;
      o_busy  = busy;

      ewe = !reset && m_valid && !hold && (m_addr != 0);
      can = !reset && (!m_valid || !hold);
      er  = '0;
      win = -1;
      if (can) begin
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (win < 0 && rv[j]) win = j;
         end
      end
      if (win >= 0) er[win] = 1'b1;

      chk("ready", 64'(ready), 64'(er));
      chk("we3",   64'(we3),   64'(ewe));
      chk("busy",  64'(busy),  64'(m_valid));
      if (m_valid) begin
         chk("wa3", 64'(wa3), 64'(m_addr));
         chk("wd3", 64'(wd3), 64'(m_data));
      end

      if (we3 === 1'b1) d_rf[wa3] = wd3;
      if (ewe) m_rf[m_addr] = m_data;

      for (int i = 0; i < NREQ; i++) begin
         if (reset || !rv[i]) begin
            waitc[i] = 0;
         end else if (ready[i]) begin
            chk("fair", 64'(waitc[i] < NREQ), 64'd1);
            waitc[i] = 0;
         end else if (can) begin
            waitc[i]++;
         end
      end

      if (reset) begin
         m_valid = 1'b0;
         m_addr  = '0;
         m_data  = '0;
         m_last  = NREQ - 1;
      end else if (win >= 0) begin
         m_valid = 1'b1;
         m_addr  = ra[win*AW +: AW];
         m_data  = rd[win*DW +: DW];
         m_last  = win;
      end else if (m_valid && !hold) begin
         m_valid = 1'b0;
      end
      m_grant = er;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      rv    = '0;
      hold  = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      rv      = '0;
      ra      = '0;
      rd      = '0;
      hold    = 1'b0;
      m_valid = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_last  = NREQ - 1;
      m_grant = '0;
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = '0;
         d_rf[i] = '0;
      end
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;

      // Single write, latency and drain
      cyc();
      cyc();
      reset = 1'b0;
      set_req(0, 1'b1, 5'd3, 32'hDEADBEEF);
      cyc();
      chk("t1_ready", 64'(o_ready), 64'b001);
      rv = '0;
      cyc();
      chk("t1_we", 64'(o_we), 64'd1);
      chk("t1_wa", 64'(o_wa), 64'd3);
      chk("t1_wd", 64'(o_wd), 64'hDEADBEEF);
      cyc();
      chk("t1_we_off", 64'(o_we), 64'd0);
      chk("t1_busy_off", 64'(o_busy), 64'd0);

      // Round-robin rotation with all requesters valid
      pulse_reset();
      set_req(0, 1'b1, 5'd1, 32'h100);
      set_req(1, 1'b1, 5'd2, 32'h200);
      set_req(2, 1'b1, 5'd3, 32'h300);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_grant", 64'(o_ready), 64'(1 << (i % 3)));
         if (i > 0) chk("rr_we", 64'(o_we), 64'd1);
      end
      rv = '0;
      cyc();

      // Write to r0 consumes a slot without firing we3
      pulse_reset();
      set_req(0, 1'b1, 5'd0, 32'h1234);
      cyc();
      chk("r0_ready", 64'(o_ready), 64'b001);
      rv = '0;
      cyc();
      chk("r0_busy", 64'(o_busy), 64'd1);
      chk("r0_we", 64'(o_we), 64'd0);

      // Hold freezes the stage and blocks grants
      pulse_reset();
      set_req(0, 1'b1, 5'd5, 32'hA5);
      cyc();
      rv = '0;
      set_req(1, 1'b1, 5'd9, 32'h77);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_we", 64'(o_we), 64'd0);
         chk("hold_ready", 64'(o_ready), 64'd0);
         chk("hold_wa", 64'(o_wa), 64'd5);
      end
      hold = 1'b0;
      cyc();
      chk("rel_we", 64'(o_we), 64'd1);
      chk("rel_wd", 64'(o_wd), 64'hA5);
      chk("rel_ready", 64'(o_ready), 64'b010);
      rv = '0;
      cyc();

      // Same destination from two requesters, later grant wins
      pulse_reset();
      set_req(0, 1'b1, 5'd7, 32'h11);
      set_req(2, 1'b1, 5'd7, 32'h22);
      cyc();
      chk("same_first", 64'(o_ready), 64'b001);
      rv[0] = 1'b0;
      cyc();
      chk("same_second", 64'(o_ready), 64'b100);
      rv = '0;
      cyc();
      cyc();
      chk("r7_final", 64'(d_rf[7]), 64'h22);

      // Reset discards a pending write and restores priority
      pulse_reset();
      set_req(0, 1'b1, 5'd4, 32'h55);
      cyc();
      reset = 1'b1;
      rv    = '0;
      cyc();
      chk("rst_we", 64'(o_we), 64'd0);
      reset = 1'b0;
      set_req(1, 1'b1, 5'd1, 32'hB1);
      set_req(2, 1'b1, 5'd2, 32'hB2);
      cyc();
      chk("rst_prio", 64'(o_ready), 64'b010);
      rv = '0;
      cyc();
      cyc();
      chk("r4_discard", 64'(d_rf[4]), 64'd0);

      // Random traffic; waiting requesters keep addr/data stable until granted
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) < 2);
         hold  = ($urandom_range(0, 99) < 25);
         for (int i = 0; i < NREQ; i++) begin
            if (!(rv[i] && !m_grant[i])) begin
               set_req(i, ($urandom_range(0, 99) < 60),
                       AW'($urandom_range(0, 7)), $urandom);
            end
         end
         cyc();
      end
      reset = 1'b0;
      hold  = 1'b0;
      rv    = '0;
      cyc();
      cyc();
      cyc();
      for (int i = 0; i < 32; i++) chk("rf_final", 64'(d_rf[i]), 64'(m_rf[i]));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
